// File: rtl/seq_mult_core_if.sv
// Handshake and data bundle for seq_mult_core.
// The requester drives start and the operands. The core returns status and the product.
interface seq_mult_core_if #(
  parameter int WORD_LENGTH = 4,
  parameter int WORD        = WORD_LENGTH * 2
);
  logic                   start;
  logic [WORD_LENGTH-1:0] multiplicand;
  logic [WORD_LENGTH-1:0] multiplier;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [WORD-1:0]        product;

  modport master (
    output start, multiplicand, multiplier,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output ready, busy, done, product
  );
endinterface

// File: rtl/seq_mult_core.sv
// Shift-and-add multiplier with a start/ready handshake and a one-cycle done pulse.
// In signed mode the loop runs on magnitudes, and the result is negated afterwards when the operand signs differ.
module seq_mult_core #(
  parameter int WORD_LENGTH = 4,
  parameter int WORD        = WORD_LENGTH * 2,
  parameter bit SIGNED      = 1'b1
) (
  input logic            clk,
  input logic            reset,
  seq_mult_core_if.slave bus
);
  localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CW-1:0]          LAST_COUNT = CW'(WORD_LENGTH - 1);
  localparam logic [CW-1:0]          ONE_CW     = CW'(1);
  localparam logic [WORD_LENGTH-1:0] ONE_WL     = WORD_LENGTH'(1);
  localparam logic [WORD-1:0]        ONE_W      = WORD'(1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [WORD-1:0]        mcand_q, mcand_d;
  logic [WORD-1:0]        acc_q, acc_d;
  logic [WORD-1:0]        product_q, product_d;
  logic [WORD_LENGTH-1:0] mult_sr_q, mult_sr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   neg_q, neg_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  // The most negative input maps to 2^(WORD_LENGTH-1), which still fits unsigned.
  function automatic logic [WORD_LENGTH-1:0] magnitude(input logic [WORD_LENGTH-1:0] x);
    if (SIGNED && x[WORD_LENGTH-1]) return ~x + ONE_WL;
    return x;
  endfunction

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mult_sr_d = mult_sr_q;
    count_d   = count_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d   = WORD'(magnitude(bus.multiplicand));
          mult_sr_d = magnitude(bus.multiplier);
          neg_d     = SIGNED && (bus.multiplicand[WORD_LENGTH-1] ^ bus.multiplier[WORD_LENGTH-1]);
          acc_d     = '0;
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (mult_sr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d   = mcand_q << 1;
        mult_sr_d = mult_sr_q >> 1;
        count_d   = count_q + ONE_CW;
        if (count_q == LAST_COUNT) state_d = FINISH;
      end
      FINISH: begin
        product_d = neg_q ? (~acc_q + ONE_W) : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mult_sr_q <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mult_sr_q <= mult_sr_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ready   = ~busy_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_core.sv
// Drives a signed and an unsigned seq_mult_core in lockstep with the same stimulus.
// Each product is compared against plain integer multiplication.
module tb_seq_mult_core;
  localparam int WL = 4;
  localparam int W  = WL * 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WL-1:0] op_a = '0;
  logic [WL-1:0] op_b = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  seq_mult_core_if #(.WORD_LENGTH(WL), .WORD(W)) if_s ();
  seq_mult_core_if #(.WORD_LENGTH(WL), .WORD(W)) if_u ();

  assign if_s.start        = start;
  assign if_s.multiplicand = op_a;
  assign if_s.multiplier   = op_b;
  assign if_u.start        = start;
  assign if_u.multiplicand = op_a;
  assign if_u.multiplier   = op_b;

  seq_mult_core #(.WORD_LENGTH(WL), .WORD(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .bus(if_s)
  );
  seq_mult_core #(.WORD_LENGTH(WL), .WORD(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .bus(if_u)
  );

  // Reference: interpret operands as integers, multiply, keep the low W bits.
  function automatic logic [W-1:0] modelProduct(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                                 input bit sgn);
    int x;
    int y;
    x = int'(a);
    y = int'(b);
    if (sgn && a[WL-1]) x = x - (1 << WL);
    if (sgn && b[WL-1]) y = y - (1 << WL);
    return W'(x * y);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One operation; for the first `junk` busy cycles, start is re-asserted with 7x7.
  task automatic applyStimulus(input logic [WL-1:0] a, input logic [WL-1:0] b, input int junk);
    int lat;
    int busy_cnt;
    logic [W-1:0] exp_s;
    logic [W-1:0] exp_u;
    exp_s = modelProduct(a, b, 1'b1);
    exp_u = modelProduct(a, b, 1'b0);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n <= junk) begin
        start = 1'b1;
        op_a  = 4'd7;
        op_b  = 4'd7;
      end else begin
        start = 1'b0;
      end
      if (if_s.busy) busy_cnt++;
      @(posedge clk); #1;
      if (if_s.done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    checkOutput("latency", lat, 5);
    checkOutput("busy_cycles", busy_cnt, 5);
    checkOutput("done_u", 32'(if_u.done), 1);
    checkOutput("ready_at_done", 32'(if_s.ready), 1);
    checkOutput("busy_at_done", 32'(if_s.busy), 0);
    checkOutput("product_s", 32'(if_s.product), 32'(exp_s));
    checkOutput("product_u", 32'(if_u.product), 32'(exp_u));
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 32'(if_s.done), 0);
    checkOutput("product_hold", 32'(if_s.product), 32'(exp_s));
  endtask

  initial begin
    int first;
    int second;
    int pulses;
    logic [WL-1:0] ra;
    logic [WL-1:0] rb;

    // Reset and idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_ready", 32'(if_s.ready), 1);
    checkOutput("rst_busy", 32'(if_s.busy), 0);
    checkOutput("rst_done", 32'(if_s.done), 0);
    checkOutput("rst_product", 32'(if_s.product), 0);
    checkOutput("rst_product_u", 32'(if_u.product), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_done", 32'(if_s.done), 0);
      checkOutput("idle_ready", 32'(if_s.ready), 1);
      checkOutput("idle_product", 32'(if_s.product), 0);
    end

    // Basic 3x5 in both modes
    applyStimulus(4'd3, 4'd5, 0);
    checkOutput("u_3x5", 32'(if_u.product), 32'h0F);
    checkOutput("s_3x5", 32'(if_s.product), 32'h0F);

    // Signed corner values
    applyStimulus(4'hD, 4'd5, 0);
    checkOutput("s_m3x5", 32'(if_s.product), 32'hF1);
    applyStimulus(4'h8, 4'h8, 0);
    checkOutput("s_m8xm8", 32'(if_s.product), 32'h40);
    applyStimulus(4'h8, 4'd7, 0);
    checkOutput("s_m8x7", 32'(if_s.product), 32'hC8);
    applyStimulus(4'd7, 4'd7, 0);
    checkOutput("s_7x7", 32'(if_s.product), 32'h31);
    applyStimulus(4'd0, 4'hB, 0);
    checkOutput("s_0xm5", 32'(if_s.product), 32'h00);

    // Start while busy is ignored
    applyStimulus(4'd3, 4'd5, 3);
    checkOutput("busy_ignore", 32'(if_s.product), 32'h0F);

    // Reset during the third RUN cycle
    op_a  = 4'd3;
    op_b  = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_ready", 32'(if_s.ready), 1);
    checkOutput("abort_product", 32'(if_s.product), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_s.done || if_u.done) pulses++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_done", pulses, 0);
    applyStimulus(4'd2, 4'd2, 0);
    checkOutput("after_abort_2x2", 32'(if_s.product), 32'h04);

    // Back-to-back with start held high
    op_a  = 4'd2;
    op_b  = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    op_a   = 4'd4;
    op_b   = 4'd4;
    first  = 0;
    second = 0;
    for (int n = 1; n <= 40 && second == 0; n++) begin
      @(posedge clk); #1;
      if (if_s.done) begin
        if (first == 0) begin
          first = n;
          checkOutput("b2b_first", 32'(if_s.product), 32'h06);
          checkOutput("b2b_first_u", 32'(if_u.product), 32'h06);
        end else begin
          second = n;
          start  = 1'b0;
          checkOutput("b2b_second", 32'(if_s.product), 32'h10);
          checkOutput("b2b_second_u", 32'(if_u.product), 32'h10);
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_first_latency", first, 5);
    checkOutput("b2b_gap", second - first, 6);
    @(posedge clk); #1;
    checkOutput("b2b_idle_after", 32'(if_s.busy), 0);

    // Random operands against the integer model
    for (int i = 0; i < 200; i++) begin
      ra = WL'($urandom);
      rb = WL'($urandom);
      applyStimulus(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
